// File: rtl/tmr_register_bank.sv
// tmr_register_bank
//
// Bank of CHANNELS registers, each WIDTH bits. With TMR=1 every channel keeps
// three copies: read-out is the bitwise majority vote, and a disagreement between
// copies is scrubbed on the next edge and reported. With TMR=0 each channel is a
// plain register, and all error outputs are tied low.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   wr_en         per-channel write strobe
//   wr_data       write data; channel i is at [i*WIDTH +: WIDTH]
//   rd_data       voted value per channel, same packing
//   inj_en        fault-injection strobe
//   inj_ch        injection target channel (out-of-range values have no effect)
//   inj_copy      injection target copy 0..2; 3 means no effect
//   inj_mask      bits XORed into the target copy
//   err_pulse     one-cycle mismatch indication per channel
//   err_sticky    latched mismatch per channel
//   err_clr       clears err_sticky and err_cnt
//   err_cnt       saturating count of cycles with at least one mismatching channel
module tmr_register_bank #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      CHANNELS = 4,
    parameter bit               TMR      = 1'b1,
    parameter logic [WIDTH-1:0] INIT     = '0,
    parameter int unsigned      CNT_W    = 8,
    localparam int unsigned     CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       wr_en,
    input  logic [CHANNELS*WIDTH-1:0] wr_data,
    output logic [CHANNELS*WIDTH-1:0] rd_data,
    input  logic                      inj_en,
    input  logic [CH_W-1:0]           inj_ch,
    input  logic [1:0]                inj_copy,
    input  logic [WIDTH-1:0]          inj_mask,
    output logic [CHANNELS-1:0]       err_pulse,
    output logic [CHANNELS-1:0]       err_sticky,
    input  logic                      err_clr,
    output logic [CNT_W-1:0]          err_cnt
);

    if (TMR) begin : g_tmr
        logic [WIDTH-1:0]    copy0_q [CHANNELS];
        logic [WIDTH-1:0]    copy1_q [CHANNELS];
        logic [WIDTH-1:0]    copy2_q [CHANNELS];
        logic [WIDTH-1:0]    voted   [CHANNELS];
        logic [CHANNELS-1:0] mismatch;
        logic                any_mismatch;
        logic [CHANNELS-1:0] pulse_q;
        logic [CHANNELS-1:0] sticky_q;
        logic [CNT_W-1:0]    cnt_q;

        localparam logic [CNT_W-1:0] CntMax = '1;

        always_comb begin
            rd_data = '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                voted[i] = (copy0_q[i] & copy1_q[i]) | (copy0_q[i] & copy2_q[i]) |
                           (copy1_q[i] & copy2_q[i]);
                // Two comparisons suffice: if 0==1 and 0==2 then all three agree.
                mismatch[i] = (copy0_q[i] != copy1_q[i]) || (copy0_q[i] != copy2_q[i]);
                rd_data[i*WIDTH +: WIDTH] = voted[i];
            end
            any_mismatch = |mismatch;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    copy0_q[i] <= INIT;
                    copy1_q[i] <= INIT;
                    copy2_q[i] <= INIT;
                end
            end else begin
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    if (wr_en[i]) begin
                        copy0_q[i] <= wr_data[i*WIDTH +: WIDTH];
                        copy1_q[i] <= wr_data[i*WIDTH +: WIDTH];
                        copy2_q[i] <= wr_data[i*WIDTH +: WIDTH];
                    end else if (mismatch[i]) begin
                        // Scrub takes priority, so an injection arriving during a
                        // scrub is dropped.
                        copy0_q[i] <= voted[i];
                        copy1_q[i] <= voted[i];
                        copy2_q[i] <= voted[i];
                    end else if (inj_en && (inj_ch == CH_W'(i))) begin
                        case (inj_copy)
                            2'd0:    copy0_q[i] <= copy0_q[i] ^ inj_mask;
                            2'd1:    copy1_q[i] <= copy1_q[i] ^ inj_mask;
                            2'd2:    copy2_q[i] <= copy2_q[i] ^ inj_mask;
                            default: ;
                        endcase
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pulse_q  <= '0;
                sticky_q <= '0;
                cnt_q    <= '0;
            end else begin
                pulse_q  <= mismatch;
                sticky_q <= (sticky_q & {CHANNELS{~err_clr}}) | mismatch;
                if (err_clr) begin
                    cnt_q <= CNT_W'(any_mismatch);
                end else if (any_mismatch && (cnt_q != CntMax)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end

        assign err_pulse  = pulse_q;
        assign err_sticky = sticky_q;
        assign err_cnt    = cnt_q;
    end else begin : g_single
        logic [WIDTH-1:0] copy_q [CHANNELS];

        always_comb begin
            rd_data = '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                rd_data[i*WIDTH +: WIDTH] = copy_q[i];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    copy_q[i] <= INIT;
                end
            end else begin
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    if (wr_en[i]) begin
                        copy_q[i] <= wr_data[i*WIDTH +: WIDTH];
                    end else if (inj_en && (inj_ch == CH_W'(i)) && (inj_copy != 2'd3)) begin
                        copy_q[i] <= copy_q[i] ^ inj_mask;
                    end
                end
            end
        end

        assign err_pulse  = '0;
        assign err_sticky = '0;
        assign err_cnt    = '0;
    end

endmodule

// File: tb/tb_tmr_register_bank.sv
module tb_tmr_register_bank;

    localparam logic [31:0] INIT = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // Shared stimulus for the two TMR instances (CNT_W = 8 and CNT_W = 2).
    logic [3:0]   wr_en = '0;
    logic [127:0] wr_data = '0;
    logic         inj_en = 1'b0;
    logic [1:0]   inj_ch = '0;
    logic [1:0]   inj_copy = '0;
    logic [31:0]  inj_mask = '0;
    logic         err_clr = 1'b0;

    logic [127:0] m_rd;
    logic [3:0]   m_pulse, m_sticky;
    logic [7:0]   m_cnt;
    logic [127:0] t_rd;
    logic [3:0]   t_pulse, t_sticky;
    logic [1:0]   t_cnt;

    // Stimulus for the single-copy instance (3 channels, so inj_ch=3 is out of range).
    logic [2:0]  s_wr_en = '0;
    logic [95:0] s_wr_data = '0;
    logic        s_inj_en = 1'b0;
    logic [1:0]  s_inj_ch = '0;
    logic [1:0]  s_inj_copy = '0;
    logic [31:0] s_inj_mask = '0;
    logic [95:0] s_rd;
    logic [2:0]  s_pulse, s_sticky;
    logic [7:0]  s_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tmr_register_bank #(
        .WIDTH(32), .CHANNELS(4), .TMR(1'b1), .INIT(INIT), .CNT_W(8)
    ) u_main (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_data(m_rd),
        .inj_en(inj_en), .inj_ch(inj_ch), .inj_copy(inj_copy), .inj_mask(inj_mask),
        .err_pulse(m_pulse), .err_sticky(m_sticky), .err_clr(err_clr), .err_cnt(m_cnt)
    );

    tmr_register_bank #(
        .WIDTH(32), .CHANNELS(4), .TMR(1'b1), .INIT(INIT), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_data(t_rd),
        .inj_en(inj_en), .inj_ch(inj_ch), .inj_copy(inj_copy), .inj_mask(inj_mask),
        .err_pulse(t_pulse), .err_sticky(t_sticky), .err_clr(err_clr), .err_cnt(t_cnt)
    );

    tmr_register_bank #(
        .WIDTH(32), .CHANNELS(3), .TMR(1'b0), .INIT(INIT), .CNT_W(8)
    ) u_single (
        .clk(clk), .rst_n(rst_n), .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_data(s_rd),
        .inj_en(s_inj_en), .inj_ch(s_inj_ch), .inj_copy(s_inj_copy),
        .inj_mask(s_inj_mask), .err_pulse(s_pulse), .err_sticky(s_sticky),
        .err_clr(1'b0), .err_cnt(s_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inject(input int ch, input int cp, input logic [31:0] mask);
        inj_en   = 1'b1;
        inj_ch   = 2'(ch);
        inj_copy = 2'(cp);
        inj_mask = mask;
        tick();
        inj_en   = 1'b0;
        inj_mask = '0;
    endtask

    initial begin
        // Reset state
        #12;
        for (int i = 0; i < 4; i++) check($sformatf("rst_rd%0d", i), 64'(m_rd[i*32 +: 32]), 64'(INIT));
        check("rst_pulse", 64'(m_pulse), 64'h0);
        check("rst_sticky", 64'(m_sticky), 64'h0);
        check("rst_cnt", 64'(m_cnt), 64'h0);
        check("rst_single_rd0", 64'(s_rd[31:0]), 64'(INIT));
        rst_n = 1'b1;
        tick();

        // Write ch2
        wr_en = 4'b0100;
        wr_data[64 +: 32] = 32'hDEAD_BEEF;
        tick();
        wr_en = '0;
        check("wr_rd2", 64'(m_rd[64 +: 32]), 64'hDEAD_BEEF);
        check("wr_rd0", 64'(m_rd[0 +: 32]), 64'(INIT));
        check("wr_rd3", 64'(m_rd[96 +: 32]), 64'(INIT));
        check("wr_pulse", 64'(m_pulse), 64'h0);

        // Single-copy upset on ch1 copy0: outvoted, scrubbed next edge, flagged once
        inject(1, 0, 32'h0000_00FF);
        check("inj_rd1_a", 64'(m_rd[32 +: 32]), 64'(INIT));
        check("inj_pulse_a", 64'(m_pulse), 64'h0);
        tick();
        check("inj_rd1_b", 64'(m_rd[32 +: 32]), 64'(INIT));
        check("inj_pulse_b", 64'(m_pulse), 64'h2);
        check("inj_sticky_b", 64'(m_sticky), 64'h2);
        check("inj_cnt_b", 64'(m_cnt), 64'h1);
        tick();
        check("inj_pulse_c", 64'(m_pulse), 64'h0);
        check("inj_sticky_c", 64'(m_sticky), 64'h2);
        check("inj_rd1_c", 64'(m_rd[32 +: 32]), 64'(INIT));

        inject(1, 0, 32'h0000_00FF);
        tick();
        check("inj2_cnt", 64'(m_cnt), 64'h2);
        check("inj2_cnt_sat", 64'(t_cnt), 64'h2);

        // Write and injection to ch3 in the same cycle: write wins
        wr_en = 4'b1000;
        wr_data[96 +: 32] = 32'h1234_5678;
        inject(3, 1, 32'h0000_00F0);
        wr_en = '0;
        check("wrinj_rd3", 64'(m_rd[96 +: 32]), 64'h1234_5678);
        tick();
        check("wrinj_pulse", 64'(m_pulse), 64'h0);
        check("wrinj_cnt", 64'(m_cnt), 64'h2);
        check("wrinj_rd3_b", 64'(m_rd[96 +: 32]), 64'h1234_5678);

        // Injection with err_clr: clear lands first, new mismatch re-sets next edge
        err_clr = 1'b1;
        inject(0, 2, 32'h0000_0001);
        err_clr = 1'b0;
        check("clr_sticky_a", 64'(m_sticky), 64'h0);
        check("clr_cnt_a", 64'(m_cnt), 64'h0);
        tick();
        check("clr_sticky_b", 64'(m_sticky), 64'h1);
        check("clr_cnt_b", 64'(m_cnt), 64'h1);
        check("clr_pulse_b", 64'(m_pulse), 64'h1);
        check("clr_rd0", 64'(m_rd[0 +: 32]), 64'(INIT));

        // Saturation: CNT_W=2 stops at 3, CNT_W=8 keeps counting
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("sat_clr_cnt", 64'(t_cnt), 64'h0);
        check("sat_clr_sticky", 64'(m_sticky), 64'h0);
        for (int k = 1; k <= 5; k++) begin
            inject(k % 4, k % 3, 32'h1 << k);
            tick();
            check($sformatf("sat_cnt8_%0d", k), 64'(m_cnt), 64'(k));
            check($sformatf("sat_cnt2_%0d", k), 64'(t_cnt), 64'((k > 3) ? 3 : k));
        end
        check("sat_rd2", 64'(m_rd[64 +: 32]), 64'hDEAD_BEEF);
        check("sat_rd3", 64'(m_rd[96 +: 32]), 64'h1234_5678);

        // Asynchronous reset mid-operation drops the pending scrub
        inject(1, 2, 32'hFFFF_0000);
        #2 rst_n = 1'b0;
        #1;
        check("arst_rd2", 64'(m_rd[64 +: 32]), 64'(INIT));
        check("arst_cnt", 64'(m_cnt), 64'h0);
        check("arst_sticky", 64'(m_sticky), 64'h0);
        #1 rst_n = 1'b1;
        tick();
        check("arst_pulse", 64'(m_pulse), 64'h0);
        check("arst_rd1", 64'(m_rd[32 +: 32]), 64'(INIT));

        // Single-copy build: the upset is visible and permanent, no error reporting
        s_inj_en = 1'b1; s_inj_ch = 2'd0; s_inj_copy = 2'd2; s_inj_mask = 32'h1;
        tick();
        s_inj_en = 1'b0;
        check("single_rd0_a", 64'(s_rd[0 +: 32]), 64'hA5A5_0000);
        tick();
        tick();
        check("single_rd0_b", 64'(s_rd[0 +: 32]), 64'hA5A5_0000);
        check("single_pulse", 64'(s_pulse), 64'h0);
        check("single_sticky", 64'(s_sticky), 64'h0);
        check("single_cnt", 64'(s_cnt), 64'h0);
        s_inj_en = 1'b1; s_inj_ch = 2'd1; s_inj_copy = 2'd3; s_inj_mask = 32'hFFFF;
        tick();
        check("single_copy3", 64'(s_rd[32 +: 32]), 64'(INIT));
        s_inj_ch = 2'd3; s_inj_copy = 2'd0;
        tick();
        s_inj_en = 1'b0;
        check("single_oor", 64'(s_rd), {32'(INIT), 32'(INIT), 32'hA5A5_0000});
        s_wr_en = 3'b010; s_wr_data[32 +: 32] = 32'h0BAD_F00D;
        tick();
        s_wr_en = '0;
        check("single_wr1", 64'(s_rd[32 +: 32]), 64'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
